// File: rtl/muldiv_if.sv
// Request/response handshake bundle for the iterative multiply/divide sequencer.
// The master modport is the requester side and the slave modport is the sequencer side.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the shared ALU for 32 cycles.
// Define MULDIV_FASTPATH_EN to short-circuit b==1 and a==0 requests straight to DONE.
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  muldiv_if.slave         bus,
  output logic            busy,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      cnt_q, cnt_d;
  // hi/lo hold {hi,lo} for multiply and {rem,quo} for divide; opnd is mcand or divisor.
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] resp_q, resp_d;

  logic            short_hit;
  logic [XLEN-1:0] short_val;
  logic [XLEN:0]   sh;
  logic            carry;
  logic            q_bit;

  // Requests that resolve without iterating; divide-by-zero always wins.
  always_comb begin
    short_hit = 1'b0;
    short_val = {XLEN{1'b0}};
    if (bus.req_op[1] && (bus.req_b == {XLEN{1'b0}})) begin
      short_hit = 1'b1;
      short_val = bus.req_op[0] ? bus.req_a : {XLEN{1'b1}};
    end
`ifdef MULDIV_FASTPATH_EN
    else if (bus.req_b == {{(XLEN-1){1'b0}}, 1'b1}) begin
      short_hit = 1'b1;
      short_val = bus.req_op[0] ? {XLEN{1'b0}} : bus.req_a;
    end else if (bus.req_a == {XLEN{1'b0}}) begin
      short_hit = 1'b1;
      short_val = {XLEN{1'b0}};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    resp_d  = resp_q;
    alu_a   = {XLEN{1'b0}};
    alu_b   = {XLEN{1'b0}};
    alu_op  = AluAdd;
    sh      = {hi_q, lo_q[XLEN-1]};
    carry   = 1'b0;
    q_bit   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          op_d  = bus.req_op;
          cnt_d = 5'd0;
          hi_d  = {XLEN{1'b0}};
          if (bus.req_op[1]) begin
            lo_d   = bus.req_a;
            opnd_d = bus.req_b;
          end else begin
            lo_d   = bus.req_b;
            opnd_d = bus.req_a;
          end
          if (short_hit) begin
            state_d = StDone;
            resp_d  = short_val;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (!op_q[1]) begin
          alu_a  = hi_q;
          alu_b  = lo_q[0] ? opnd_q : {XLEN{1'b0}};
          alu_op = AluAdd;
          carry  = (alu_result < alu_a);
          hi_d   = {carry, alu_result[XLEN-1:1]};
          lo_d   = {alu_result[0], lo_q[XLEN-1:1]};
        end else begin
          alu_a  = sh[XLEN-1:0];
          alu_b  = opnd_q;
          alu_op = AluSub;
          // 33-bit compare: the shifted remainder can exceed 32 bits.
          q_bit  = (sh >= {1'b0, opnd_q});
          hi_d   = q_bit ? alu_result : sh[XLEN-1:0];
          lo_d   = {lo_q[XLEN-2:0], q_bit};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
          // op[0] selects the upper word (MULHU) or remainder (REMU).
          resp_d  = op_q[0] ? hi_d : lo_d;
        end
      end
      StDone: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 2'b00;
      cnt_q   <= 5'd0;
      hi_q    <= {XLEN{1'b0}};
      lo_q    <= {XLEN{1'b0}};
      opnd_q  <= {XLEN{1'b0}};
      resp_q  <= {XLEN{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StDone);
  assign bus.resp_data  = resp_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed, table-driven bench for muldiv_seq with a behavioural add/sub ALU beside it.
// Expected latencies follow MULDIV_FASTPATH_EN when it is defined for the build.
module tb_muldiv_seq;

  localparam logic [1:0] OpMul   = 2'b00;
  localparam logic [1:0] OpMulhu = 2'b01;
  localparam logic [1:0] OpDivu  = 2'b10;
  localparam logic [1:0] OpRemu  = 2'b11;

  localparam int LatRun = 33;
  localparam int LatDz  = 1;
`ifdef MULDIV_FASTPATH_EN
  localparam int LatFp  = 1;
`else
  localparam int LatFp  = 33;
`endif

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;

  int total = 0;
  int bad   = 0;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  assign alu_result = (alu_op == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    for (int t = 0; t < 200 && !bus.req_ready; t++) @(negedge clk);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Called #1 after the accepting edge; lat counts edges from accept up to resp_valid.
  task automatic wait_resp(input logic [1:0] op, output int lat, output logic [31:0] data,
                           output int alu_err);
    logic [3:0] want_op;
    want_op = op[1] ? 4'b0001 : 4'b0000;
    lat     = 1;
    alu_err = 0;
    while (!bus.resp_valid && lat < 100) begin
      if (busy && alu_op !== want_op) alu_err++;
      @(posedge clk);
      #1;
      lat++;
    end
    data = bus.resp_data;
  endtask

  task automatic consume(input string name);
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check({name, " idle after consume"}, {62'd0, bus.req_ready, bus.resp_valid}, 64'b10);
  endtask

  task automatic run_vec(input vec_t v);
    int          lat;
    int          alu_err;
    logic [31:0] data;
    start_req(v.op, v.a, v.b);
    wait_resp(v.op, lat, data, alu_err);
    check({v.name, " data"}, 64'(data), 64'(v.exp));
    check({v.name, " latency"}, 64'(lat), 64'(v.lat));
    check({v.name, " alu_op in run"}, 64'(alu_err), 64'd0);
    consume(v.name);
  endtask

  vec_t vecs[14];

  initial begin
    int          lat;
    int          alu_err;
    logic [31:0] data;

    vecs[0]  = '{"mul 7*6",        OpMul,   32'd7,         32'd6,         32'd42,        LatRun};
    vecs[1]  = '{"mulhu ff*ff",    OpMulhu, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  LatRun};
    vecs[2]  = '{"mul ff*ff",      OpMul,   32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  LatRun};
    vecs[3]  = '{"divu 100/7",     OpDivu,  32'd100,       32'd7,         32'd14,        LatRun};
    vecs[4]  = '{"remu 100%7",     OpRemu,  32'd100,       32'd7,         32'd2,         LatRun};
    vecs[5]  = '{"divu big",       OpDivu,  32'hFFFFFFFF,  32'h80000001,  32'd1,         LatRun};
    vecs[6]  = '{"remu big",       OpRemu,  32'hFFFFFFFF,  32'h80000001,  32'h7FFFFFFE,  LatRun};
    vecs[7]  = '{"divu by zero",   OpDivu,  32'd5,         32'd0,         32'hFFFFFFFF,  LatDz};
    vecs[8]  = '{"remu by zero",   OpRemu,  32'd5,         32'd0,         32'd5,         LatDz};
    vecs[9]  = '{"mul 9*1",        OpMul,   32'd9,         32'd1,         32'd9,         LatFp};
    vecs[10] = '{"mulhu shift",    OpMulhu, 32'h12345678,  32'h10,        32'h1,         LatRun};
    vecs[11] = '{"mul shift",      OpMul,   32'h12345678,  32'h10,        32'h23456780,  LatRun};
    vecs[12] = '{"remu deadbeef",  OpRemu,  32'hDEADBEEF,  32'h10,        32'hF,         LatRun};
    vecs[13] = '{"mul a zero",     OpMul,   32'd0,         32'd5,         32'd0,         LatFp};

    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_a      = 32'd0;
    bus.req_b      = 32'd0;
    bus.resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready/resp_valid/busy",
          {61'd0, bus.req_ready, bus.resp_valid, busy}, 64'b100);
    check("reset resp_data", 64'(bus.resp_data), 64'd0);
    check("reset alu lines", {alu_op, alu_a, 28'd0}, 64'd0);
    check("reset alu_b", 64'(alu_b), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Backpressure: response must hold while a competing request waits.
    start_req(OpMul, 32'd3, 32'd4);
    wait_resp(OpMul, lat, data, alu_err);
    check("bp first data", 64'(data), 64'd12);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OpDivu;
    bus.req_a     = 32'd100;
    bus.req_b     = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp hold", {30'd0, bus.resp_valid, bus.req_ready, bus.resp_data}, {30'd0, 2'b10, 32'd12});
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check("bp no accept on consume", {62'd0, bus.req_ready, busy}, 64'b10);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("bp accepted after idle", {62'd0, bus.req_ready, busy}, 64'b01);
    wait_resp(OpDivu, lat, data, alu_err);
    check("bp second data", 64'(data), 64'd14);
    check("bp second latency", 64'(lat), 64'(LatRun));
    consume("bp second");

    // Reset mid-run at iteration 15 discards the operation.
    start_req(OpMul, 32'd3, 32'd5);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort state", {61'd0, bus.req_ready, bus.resp_valid, busy}, 64'b100);
    check("abort alu lines", {alu_op, alu_a, 28'd0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec('{"mul 3*5 after abort", OpMul, 32'd3, 32'd5, 32'd15, LatRun});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative unsigned multiply/divide sequencer. It time-shares the 32-bit RV32I ALU to execute MUL, MULHU, DIVU and REMU over 32 cycles.
- Sits beside the ALU in the execute stage. While busy it owns the ALU operand/op lines and reads the ALU result combinationally each cycle.
- Valid/ready handshake on both the request and response sides.

Parameters:
- XLEN, 32, operand width. Fixed at 32; other values unsupported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  00 MUL, 01 MULHU, 10 DIVU, 11 REMU
- req_a  in  32  multiplicand / dividend
- req_b  in  32  multiplier / divisor
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  32  result
- busy  out  1  high in RUN or DONE
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_op  out  4  ALU op code (0000 add, 0001 sub)
- alu_result  in  32  ALU result, combinational

Behaviour:
- Interface: one clock clk; synchronous active-high reset rst.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, busy=0, alu_a=0, alu_b=0, alu_op=0000, internal counter and registers cleared.
- States:
  - IDLE: req_ready=1.
  - RUN: 32 iterations, counter 0..31.
  - DONE: resp_valid=1.
- Accept: req_valid&&req_ready at edge N latches op and operands and enters RUN. The ALU is driven from cycle N+1.
- Divide by zero (DIVU/REMU with req_b==0): go directly IDLE->DONE. DIVU result=32'hFFFFFFFF, REMU result=req_a. resp_valid is seen the cycle after accept.
- MUL/MULHU iteration:
  - Registers hi (init 0), lo (init req_b), mcand (req_a).
  - Drive alu_a=hi, alu_b=lo[0]?mcand:0, alu_op=0000.
  - carry = (alu_result < alu_a) unsigned, compared locally.
  - Update: {hi,lo} <= {carry,alu_result,lo[31:1]}.
- DIVU/REMU iteration (restoring):
  - Registers rem (init 0), quo (init req_a), dvs (req_b).
  - sh = {rem,quo[31]} (33 bit).
  - Drive alu_a=sh[31:0], alu_b=dvs, alu_op=0001.
  - q = (sh >= {1'b0,dvs}), 33-bit local compare.
  - Update: rem <= q?alu_result:sh[31:0]; quo <= {quo[30:0],q}.
- After iteration 31 (counter==31), go to DONE with resp_data: MUL=lo, MULHU=hi, DIVU=quo, REMU=rem.
- Latency: resp_valid first high at cycle N+33 for a request accepted at edge N.
- DONE: resp_data and resp_valid held stable until resp_ready. On resp_valid&&resp_ready go to IDLE; req_ready rises the next cycle. No request is accepted in the same cycle a response is consumed.
- ALU lines return to a=0, b=0, op=0000 in IDLE and DONE.
- req_ready=0 in RUN and DONE. Requests during those states are ignored; the requester holds them.
- rst asserted in RUN or DONE: abort, return to IDLE with reset values, response discarded.
- resp_ready while not in DONE: ignored.

Optional Feature:
- Macro: MULDIV_FASTPATH_EN.
- Defined: at accept, with divide-by-zero taking precedence, go IDLE->DONE without RUN when:
  - req_b==1: MUL=req_a, MULHU=0, DIVU=req_a, REMU=0.
  - else req_a==0: result 0 for all ops.
- Not defined: only divide-by-zero short-circuits; all other requests take 32 RUN cycles.

Test Plan:
- MUL a=7 b=6, resp_ready=1 -> resp_data=42, resp_valid exactly 33 cycles after accept. alu_op=0000 throughout RUN.
- MULHU and MUL, a=b=32'hFFFFFFFF -> MULHU 32'hFFFFFFFE, MUL 32'h00000001 (exercises carry path).
- DIVU/REMU a=100 b=7 -> 14 / 2. Also a=32'hFFFFFFFF b=32'h80000001 -> quotient 1, remainder 32'h7FFFFFFE (exercises 33-bit compare).
- DIVU a=5 b=0 -> 32'hFFFFFFFF one cycle after accept. REMU a=5 b=0 -> 5.
- Backpressure: hold resp_ready=0 for 10 cycles in DONE -> resp_data stable, req_ready=0, a new req_valid is not accepted. After resp_ready -> IDLE, then the new request is accepted.
- rst pulse at RUN iteration 15 -> next cycle IDLE, req_ready=1, resp_valid=0. A subsequent MUL 3*5 returns 15.
- With MULDIV_FASTPATH_EN: MUL a=9 b=1 -> 9 one cycle after accept. Without it: same result after 33 cycles.
